// File: rtl/ae_controller.sv
// ae_controller: closed-loop auto-exposure controller stepping sensor exposure and gain once per frame
//   clk               in   pixel-domain clock
//   rst_n             in   asynchronous active-low reset
//   ae_en             in   controller enable (level)
//   target_luma       in   [7:0]  target average luma
//   avg_brightness_in in   [7:0]  frame average, valid with frame_done_in
//   frame_done_in     in   one-cycle pulse per frame
//   exposure_out      out  [15:0] current exposure, lines
//   gain_out          out  [7:0]  current analogue gain, Q4.4
//   cfg_valid         out  new exposure/gain pair awaiting the register writer
//   cfg_ready         in   register writer accepts the pair
//   ae_locked         out  last evaluated frame was inside the lock window
// Build option: define AE_IIR_EN to feed the error calculation from a quarter-weight IIR-filtered luma.
module ae_controller #(
    parameter int EXP_MIN     = 16,
    parameter int EXP_MAX     = 748,
    parameter int EXP_INIT    = 400,
    parameter int GAIN_MIN    = 16,
    parameter int GAIN_MAX    = 128,
    parameter int GAIN_INIT   = 16,
    parameter int HYST        = 8,
    parameter int STEP_SHIFT  = 2,
    parameter int SKIP_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ae_en,
    input  logic [7:0]  target_luma,
    input  logic [7:0]  avg_brightness_in,
    input  logic        frame_done_in,
    output logic [15:0] exposure_out,
    output logic [7:0]  gain_out,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic        ae_locked
);
    typedef enum logic [1:0] {IDLE, CALC, ADJUST, ISSUE} state_t;
    localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [15:0] EXP_MAX_V  = 16'(EXP_MAX);
    localparam logic [15:0] EXP_MIN_V  = 16'(EXP_MIN);
    localparam logic [7:0]  GAIN_MAX_V = 8'(GAIN_MAX);
    localparam logic [7:0]  GAIN_MIN_V = 8'(GAIN_MIN);
    localparam logic [7:0]  HYST_V     = 8'(HYST);
    localparam logic signed [16:0] EXP_MAX_S  = 17'(EXP_MAX);
    localparam logic signed [16:0] EXP_MIN_S  = 17'(EXP_MIN);
    localparam logic signed [16:0] GAIN_MAX_S = 17'(GAIN_MAX);
    localparam logic signed [16:0] GAIN_MIN_S = 17'(GAIN_MIN);
    state_t state, state_nx;
    logic [7:0] luma, luma_nx, step, step_nx, gain_nx, mag, shifted, adj_gain;
    logic [15:0] exp_nx, adj_exp;
    logic [SW-1:0] skip_cnt, skip_nx;
    logic dark, dark_nx, valid_nx, locked_nx;
    logic signed [8:0] err;
    logic signed [16:0] exp_up, exp_dn, gain_up, gain_dn;
`ifdef AE_IIR_EN
    logic primed, primed_nx;
    logic signed [9:0] f_diff, f_sum;
    assign f_diff = $signed({2'b00, avg_brightness_in}) - $signed({2'b00, luma});
    assign f_sum  = $signed({2'b00, luma}) + (f_diff >>> 2);
`endif
    assign err     = $signed({1'b0, luma}) - $signed({1'b0, target_luma});
    assign mag     = err[8] ? 8'(-err) : err[7:0];
    assign shifted = mag >> STEP_SHIFT;
    // 17-bit signed intermediates so over/underflow is visible before saturation
    assign exp_up  = $signed({1'b0, exposure_out}) + $signed({7'b0, step, 2'b00});
    assign exp_dn  = $signed({1'b0, exposure_out}) - $signed({7'b0, step, 2'b00});
    assign gain_up = $signed({9'b0, gain_out}) + $signed({9'b0, step});
    assign gain_dn = $signed({9'b0, gain_out}) - $signed({9'b0, step});
    // Dark frames raise exposure first and gain only once exposure is pinned;
    // bright frames shed gain first so noise is minimised.
    always_comb begin
        adj_exp  = exposure_out;
        adj_gain = gain_out;
        if (dark) begin
            if (exposure_out < EXP_MAX_V) adj_exp = (exp_up > EXP_MAX_S) ? EXP_MAX_V : exp_up[15:0];
            else adj_gain = (gain_up > GAIN_MAX_S) ? GAIN_MAX_V : gain_up[7:0];
        end else begin
            if (gain_out > GAIN_MIN_V) adj_gain = (gain_dn < GAIN_MIN_S) ? GAIN_MIN_V : gain_dn[7:0];
            else adj_exp = (exp_dn < EXP_MIN_S) ? EXP_MIN_V : exp_dn[15:0];
        end
    end
    always_comb begin
        state_nx  = state;
        luma_nx   = luma;
        skip_nx   = skip_cnt;
        step_nx   = step;
        dark_nx   = dark;
        exp_nx    = exposure_out;
        gain_nx   = gain_out;
        valid_nx  = cfg_valid;
        locked_nx = ae_locked;
`ifdef AE_IIR_EN
        primed_nx = ae_en ? primed : 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!ae_en) begin
                    locked_nx = 1'b0;
                    skip_nx   = '0;
                end else if (frame_done_in) begin
`ifdef AE_IIR_EN
                    luma_nx   = primed ? f_sum[7:0] : avg_brightness_in;
                    primed_nx = 1'b1;
`else
                    luma_nx   = avg_brightness_in;
`endif
                    if (skip_cnt != '0) skip_nx = skip_cnt - 1'b1;
                    else state_nx = CALC;
                end
            end
            CALC: begin
                state_nx = IDLE;
                if (!ae_en) begin
                    locked_nx = 1'b0;
                    skip_nx   = '0;
                end else if (mag <= HYST_V) begin
                    locked_nx = 1'b1;
                end else begin
                    locked_nx = 1'b0;
                    step_nx   = (shifted == 8'd0) ? 8'd1 : shifted;
                    dark_nx   = err[8];
                    state_nx  = ADJUST;
                end
            end
            ADJUST: begin
                state_nx = IDLE;
                if (!ae_en) begin
                    locked_nx = 1'b0;
                    skip_nx   = '0;
                end else if (adj_exp != exposure_out || adj_gain != gain_out) begin
                    exp_nx   = adj_exp;
                    gain_nx  = adj_gain;
                    valid_nx = 1'b1;
                    state_nx = ISSUE;
                end
            end
            default: begin
                // handshake always completes, even if ae_en has dropped
                if (cfg_ready) begin
                    valid_nx = 1'b0;
                    skip_nx  = SW'(SKIP_FRAMES);
                    state_nx = IDLE;
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            luma         <= '0;
            skip_cnt     <= '0;
            step         <= '0;
            dark         <= 1'b0;
            exposure_out <= 16'(EXP_INIT);
            gain_out     <= 8'(GAIN_INIT);
            cfg_valid    <= 1'b0;
            ae_locked    <= 1'b0;
`ifdef AE_IIR_EN
            primed       <= 1'b0;
`endif
        end else begin
            state        <= state_nx;
            luma         <= luma_nx;
            skip_cnt     <= skip_nx;
            step         <= step_nx;
            dark         <= dark_nx;
            exposure_out <= exp_nx;
            gain_out     <= gain_nx;
            cfg_valid    <= valid_nx;
            ae_locked    <= locked_nx;
`ifdef AE_IIR_EN
            primed       <= primed_nx;
`endif
        end
    end
endmodule

// File: tb/tb_ae_controller.sv
// tb_ae_controller: randomized self-checking bench for ae_controller against a per-frame behavioural model
module tb_ae_controller;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        ae_en = 1;
    logic [7:0]  target = 128;
    logic [7:0]  avg_in = 0;
    logic        frame_done = 0;
    logic [15:0] exposure_out;
    logic [7:0]  gain_out;
    logic        cfg_valid;
    logic        cfg_ready = 1;
    logic        ae_locked;
    int n_tests = 0;
    int n_fail = 0;
    int m_exp = 400;
    int m_gain = 16;
    int m_skip = 0;
    bit m_locked = 0;
    ae_controller dut (
        .clk(clk), .rst_n(rst_n), .ae_en(ae_en), .target_luma(target),
        .avg_brightness_in(avg_in), .frame_done_in(frame_done),
        .exposure_out(exposure_out), .gain_out(gain_out), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .ae_locked(ae_locked)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask
    task automatic model_reset();
        m_exp = 400;
        m_gain = 16;
        m_skip = 0;
        m_locked = 0;
    endtask
    // One evaluated frame, straight from the control rules with integer arithmetic.
    task automatic model_eval(input int avg, input int tgt, output bit upd);
        int e, mag, step, pe, pg;
        e = avg - tgt;
        mag = (e < 0) ? -e : e;
        pe = m_exp;
        pg = m_gain;
        if (mag <= 8) begin
            m_locked = 1;
        end else begin
            m_locked = 0;
            step = (mag / 4 < 1) ? 1 : mag / 4;
            if (e < 0) begin
                if (m_exp < 748) m_exp = (m_exp + 4 * step > 748) ? 748 : m_exp + 4 * step;
                else m_gain = (m_gain + step > 128) ? 128 : m_gain + step;
            end else begin
                if (m_gain > 16) m_gain = (m_gain - step < 16) ? 16 : m_gain - step;
                else m_exp = (m_exp - 4 * step < 16) ? 16 : m_exp - 4 * step;
            end
        end
        upd = (pe != m_exp) || (pg != m_gain);
    endtask
    // Pulse one frame and check through cycle N+3 (mid-cycle sampling).
    task automatic start_frame(input int avg, input int tgt, input bit rdy, output bit upd);
        avg_in = 8'(avg);
        target = 8'(tgt);
        cfg_ready = rdy;
        @(posedge clk); #1 frame_done = 1;
        @(posedge clk); #1 frame_done = 0;
        upd = 0;
        if (m_skip > 0) m_skip--;
        else model_eval(avg, tgt, upd);
        @(posedge clk); @(negedge clk);
        check("valid_n2", cfg_valid, 0);
        @(posedge clk); @(negedge clk);
        check("valid_n3", cfg_valid, upd);
        check("exp", exposure_out, m_exp);
        check("gain", gain_out, m_gain);
        check("locked", ae_locked, m_locked);
    endtask
    task automatic finish_hs(input int dly);
        bit ok = 1;
        repeat (dly) begin
            @(posedge clk); @(negedge clk);
            if (cfg_valid !== 1 || exposure_out != 16'(m_exp) || gain_out != 8'(m_gain)) ok = 0;
        end
        if (dly > 0) check("hold", ok, 1);
        cfg_ready = 1;
        @(posedge clk); @(negedge clk);
        check("valid_drop", cfg_valid, 0);
        m_skip = 2;
    endtask
    task automatic do_frame(input int avg, input int tgt, input int dly);
        bit upd;
        start_frame(avg, tgt, dly == 0, upd);
        if (upd) finish_hs(dly);
    endtask
    task automatic drain(input int avg, input int tgt);
        while (m_skip > 0) do_frame(avg, tgt, 0);
    endtask
    task automatic disable_burst();
        bit quiet = 1;
        @(posedge clk); #1 ae_en = 0;
        avg_in = 0;
        target = 200;
        frame_done = 1;
        @(posedge clk); #1 frame_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (cfg_valid !== 0) quiet = 0;
        end
        m_locked = 0;
        m_skip = 0;
        check("dis_quiet", quiet, 1);
        check("dis_unlock", ae_locked, 0);
        check("dis_exp", exposure_out, m_exp);
        check("dis_gain", gain_out, m_gain);
        ae_en = 1;
    endtask
    initial begin
        bit upd, ok;
        int tgt, avg;
        repeat (3) @(negedge clk);
        check("rst_exp", exposure_out, 400);
        check("rst_gain", gain_out, 16);
        check("rst_valid", cfg_valid, 0);
        check("rst_locked", ae_locked, 0);
        rst_n = 1;
        @(negedge clk);
        do_frame(40, 128, 0);
        check("first_exp488", exposure_out, 488);
        check("first_gain16", gain_out, 16);
        do_frame(40, 128, 0);
        do_frame(40, 128, 0);
        check("skip_exp488", exposure_out, 488);
        do_frame(130, 128, 0);
        check("lock_set", ae_locked, 1);
        check("lock_exp", exposure_out, 488);
        for (int i = 0; i < 20 && !(m_exp == 748 && m_skip == 0); i++)
            do_frame(0, 128, $urandom_range(3));
        do_frame(0, 128, 0);
        check("gain48", gain_out, 48);
        check("exp748", exposure_out, 748);
        drain(128, 128);
        do_frame(240, 128, 1);
        check("gain20", gain_out, 20);
        drain(255, 128);
        do_frame(255, 128, 0);
        check("gain_floor16", gain_out, 16);
        drain(255, 128);
        do_frame(255, 128, 0);
        check("exp624", exposure_out, 624);
        check("gain_keep16", gain_out, 16);
        drain(0, 128);
        start_frame(0, 128, 0, upd);
        ok = 1;
        for (int c = 0; c < 100; c++) begin
            if (c == 10 || c == 40 || c == 70) begin
                @(posedge clk); #1 frame_done = 1;
                @(negedge clk); frame_done = 0;
            end else begin
                @(negedge clk);
            end
            if (cfg_valid !== 1 || exposure_out != 16'(m_exp) || gain_out != 8'(m_gain)) ok = 0;
        end
        check("stall_hold", ok, 1);
        cfg_ready = 1;
        @(posedge clk); @(negedge clk);
        check("stall_release", cfg_valid, 0);
        m_skip = 2;
        ok = 1;
        repeat (12) begin
            @(negedge clk);
            if (cfg_valid !== 0) ok = 0;
        end
        check("single_hs", ok, 1);
        drain(0, 128);
        disable_burst();
        for (int f = 0; f < 120; f++) begin
            tgt = int'($urandom_range(255));
            if ($urandom_range(3) == 0) begin
                avg = tgt + int'($urandom_range(16)) - 8;
                avg = (avg < 0) ? 0 : (avg > 255) ? 255 : avg;
            end else begin
                avg = int'($urandom_range(255));
            end
            do_frame(avg, tgt, int'($urandom_range(4)));
            if ($urandom_range(19) == 0) disable_burst();
        end
        drain(128, 128);
        start_frame(0, 200, 0, upd);
        #2 rst_n = 0;
        #1;
        check("arst_valid", cfg_valid, 0);
        check("arst_exp", exposure_out, 400);
        check("arst_gain", gain_out, 16);
        check("arst_locked", ae_locked, 0);
        model_reset();
        @(negedge clk) rst_n = 1;
        do_frame(40, 128, 0);
        check("post_rst_exp", exposure_out, 488);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
